uart_rx_core: RTL

//  Serial receive engine for the APB UART: sits between the RX pin and the receive FIFO.

---
 rtl/uart_rx_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// 8N1 serial receive engine: fractional 16x oversample tick, 2-flop RX synchroniser,
// deframer FSM and a one-entry holding register with a valid/ready write port.
module uart_rx_core #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned DIV_INT_WIDTH  = 16,
  parameter int unsigned DIV_FRAC_WIDTH = 4
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      enable,
  input  logic [DIV_INT_WIDTH-1:0]  div_int,
  input  logic [DIV_FRAC_WIDTH-1:0] div_frac,
  input  logic                      rx_i,
  output logic [DATA_BITS-1:0]      rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      break_det,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned LimW  = DIV_INT_WIDTH + 1;
  localparam int unsigned BidxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  // Oversample tick generator
  logic [DIV_INT_WIDTH-1:0]  tcnt_q, tcnt_d;
  logic [DIV_FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                      carry_q, carry_d;
  logic [LimW-1:0]           tick_limit;
  logic                      div_ok;
  logic                      tick;

  assign div_ok     = (div_int >= DIV_INT_WIDTH'(2));
  assign tick_limit = {1'b0, div_int} - LimW'(1) + LimW'(carry_q);
  // >= rather than == so a divider shrunk mid-count cannot run the counter around
  assign tick       = enable && div_ok && ({1'b0, tcnt_q} >= tick_limit);

  always_comb begin
    tcnt_d  = tcnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (!enable || !div_ok) begin
      tcnt_d  = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (tick) begin
      tcnt_d             = '0;
      {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, div_frac};
    end else begin
      tcnt_d = tcnt_q + DIV_INT_WIDTH'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  logic [1:0] sync_q;
  logic       rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  // Deframer FSM, holding register and registered status pulses
  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [BidxW-1:0]     bidx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 deliver_q;
  logic                 frame_err_q;
  logic                 break_q;
  logic                 overrun_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;

      if (!enable) begin
        state_q <= StIdle;
      end else if (tick) begin
        case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == 4'd7) begin
              if (!rx_s) begin
                state_q <= StData;
                cnt_q   <= '0;
                bidx_q  <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          StData: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bidx_q  <= bidx_q + BidxW'(1);
              if (bidx_q == BidxW'(DATA_BITS - 1)) begin
                state_q <= StStop;
              end
            end
          end
          StStop: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              if (rx_s) begin
                deliver_q <= 1'b1;
                state_q   <= StIdle;
              end else begin
                frame_err_q <= 1'b1;
                break_q     <= (shift_q == '0);
                state_q     <= StWaitHigh;
              end
            end
          end
          StWaitHigh: begin
            if (rx_s) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // A full holding register only accepts a new byte if it drains on the same edge
      if (deliver_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign break_det = break_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule
